alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_core.sv | 56 +++++
 rtl/alu.sv | 74 +++++++
 tb/tb_alu.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width and the 3-bit operation encoding.
// Used by alu_core and alu. Optional feature macro: ALU_OVERFLOW_EN.
package alu_pkg;

    // Operand/result width; 32 is the only supported value.
    localparam int WIDTH = 32;

    // Operation select encoding carried on ALUop.
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_OR   = 3'b010,
        OP_AND  = 3'b011,
        OP_SLT  = 3'b100,
        OP_SLTU = 3'b101,
        OP_XOR  = 3'b110,
        OP_SLL  = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result (and optional signed overflow) from op, A, B.
// Optional feature macro: ALU_OVERFLOW_EN adds the overflow output.
module alu_core
    import alu_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  alu_op_e        op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
`ifdef ALU_OVERFLOW_EN
    output logic           overflow,
`endif
    output logic [W-1:0]   result
);

    logic [W-1:0] sum;
    logic [W-1:0] diff;
    logic         lt_s;
    logic         lt_u;

    assign sum  = a + b;
    assign diff = a - b;
    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;

    // Operation mux; SLL uses only the low five bits of A as the shift amount.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = sum;
            OP_SUB:  result = diff;
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            OP_SLT:  result = {{(W-1){1'b0}}, lt_s};
            OP_SLTU: result = {{(W-1){1'b0}}, lt_u};
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = b << a[4:0];
            default: result = '0;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    // Signed overflow: ADD when like-signed operands yield a sign flip,
    // SUB when unlike-signed operands yield a result whose sign differs from A.
    always_comb begin
        overflow = 1'b0;
        case (op)
            OP_ADD:  overflow = (a[W-1] == b[W-1]) && (sum[W-1]  != a[W-1]);
            OP_SUB:  overflow = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            default: overflow = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/alu.sv
// Registered ALU: one-cycle latency, a new operation every cycle.
// Holds only the output registers and zero-flag generation around alu_core.
// Optional feature macro: ALU_OVERFLOW_EN adds a registered overflow port.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       ALUop,
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    output logic [WIDTH-1:0] ALU_result,
`ifdef ALU_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             zero
);

    logic [WIDTH-1:0] core_result;
    logic [WIDTH-1:0] alu_result_d, alu_result_q;
    logic             zero_d, zero_q;
`ifdef ALU_OVERFLOW_EN
    logic             core_overflow;
    logic             overflow_d, overflow_q;
`endif

    alu_core #(
        .W        (WIDTH)
    ) u_core (
        .op       (alu_op_e'(ALUop)),
        .a        (input_1),
        .b        (input_2),
`ifdef ALU_OVERFLOW_EN
        .overflow (core_overflow),
`endif
        .result   (core_result)
    );

    // Next-state: zero is derived from the value being registered, so both
    // outputs always describe the same operation.
    always_comb begin
        alu_result_d = core_result;
        zero_d       = ~|core_result;
`ifdef ALU_OVERFLOW_EN
        overflow_d   = core_overflow;
`endif
    end

    // Output registers; reset forces the "result is zero" state immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result_q <= '0;
            zero_q       <= 1'b1;
`ifdef ALU_OVERFLOW_EN
            overflow_q   <= 1'b0;
`endif
        end else begin
            alu_result_q <= alu_result_d;
            zero_q       <= zero_d;
`ifdef ALU_OVERFLOW_EN
            overflow_q   <= overflow_d;
`endif
        end
    end

    assign ALU_result = alu_result_q;
    assign zero       = zero_q;
`ifdef ALU_OVERFLOW_EN
    assign overflow   = overflow_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: arithmetic reference model plus directed vectors.
module tb_alu;

    logic        clk;
    logic        reset;
    logic [2:0]  ALUop;
    logic [31:0] input_1;
    logic [31:0] input_2;
    logic [31:0] ALU_result;
    logic        zero;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_ovf;

    alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .ALUop      (ALUop),
        .input_1    (input_1),
        .input_2    (input_2),
        .ALU_result (ALU_result),
`ifdef ALU_OVERFLOW_EN
        .overflow   (overflow),
`endif
        .zero       (zero)
    );

    initial begin
        clk = 0;
        #5;
        forever #5 clk = ~clk;
    end

    localparam longint TWO32 = 64'sh1_0000_0000;

    // Reference result from plain integer arithmetic on the operand values.
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r;
        case (op)
            3'd0: r = (ua + ub) % TWO32;
            3'd1: r = (ua - ub + TWO32) % TWO32;
            3'd2: r = longint'(a | b);
            3'd3: r = longint'(a & b);
            3'd4: r = (sa < sb) ? 1 : 0;
            3'd5: r = (ua < ub) ? 1 : 0;
            3'd6: r = longint'(a ^ b);
            default: begin
                r = ub;
                for (int k = 0; k < (a % 32); k++) r = (r * 2) % TWO32;
            end
        endcase
        return r[31:0];
    endfunction

    // Signed overflow: the true signed sum/difference falls outside 32-bit range.
    function automatic logic ref_ovf(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        if (op == 3'd0)      s = sa + sb;
        else if (op == 3'd1) s = sa - sb;
        else return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, req, $time);
        end
    endtask

    // Model state: what the registered outputs must hold after each edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_res  = 32'd0;
            exp_zero = 1'b1;
            exp_ovf  = 1'b0;
        end else begin
            exp_res  = ref_res(ALUop, input_1, input_2);
            exp_zero = (exp_res == 32'd0);
            exp_ovf  = ref_ovf(ALUop, input_1, input_2);
        end
    end

    // Compare process: outputs are checked against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_result", ALU_result, exp_res);
            chk("cmp_zero", {31'd0, zero}, {31'd0, exp_zero});
`ifdef ALU_OVERFLOW_EN
            chk("cmp_overflow", {31'd0, overflow}, {31'd0, exp_ovf});
`endif
        end
    end

    task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez);
        @(negedge clk);
        ALUop = op; input_1 = a; input_2 = b;
        @(posedge clk); #1;
        chk(nm, ALU_result, er);
        chk({nm, "_zero"}, {31'd0, zero}, {31'd0, ez});
    endtask

    initial begin
        logic [2:0]  ops [8];
        logic [31:0] held;
        ops = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

        // Reset with nonzero inputs, before any clock edge.
        reset = 1; ALUop = 3'd2; input_1 = 32'h1234_5678; input_2 = 32'h1;
        #1;
        chk("reset_result", ALU_result, 32'd0);
        chk("reset_zero", {31'd0, zero}, 32'd1);
`ifdef ALU_OVERFLOW_EN
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
`endif
        @(posedge clk); #1;
        chk("reset_hold_result", ALU_result, 32'd0);
        @(negedge clk);
        reset = 0;
        cmp_en = 1;

        // Model pins: hand-computed literals.
        chk("model_sub", ref_res(3'd1, 32'd5, 32'd3), 32'd2);
        chk("model_sll31", ref_res(3'd7, 32'd31, 32'd3), 32'h8000_0000);
        chk("model_slt", ref_res(3'd4, 32'hFFFF_FFFF, 32'd1), 32'd1);
        chk("model_ovf", {31'd0, ref_ovf(3'd0, 32'h7FFF_FFFF, 32'd1)}, 32'd1);

        // Directed vectors.
        do_op("sub_0_0",      3'd1, 32'd0,          32'd0,          32'd0,          1'b1);
        do_op("sub_5_3",      3'd1, 32'd5,          32'd3,          32'd2,          1'b0);
        do_op("sub_3_5",      3'd1, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0);
        do_op("add_wrap",     3'd0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1);
        do_op("add_ovf",      3'd0, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0);
`ifdef ALU_OVERFLOW_EN
        chk("add_ovf_flag", {31'd0, overflow}, 32'd1);
`endif
        do_op("sub_ovf",      3'd1, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0);
        do_op("slt_neg",      3'd4, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0);
        do_op("sltu_big",     3'd5, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1);
        do_op("slt_pos",      3'd4, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1);
        do_op("sltu_small",   3'd5, 32'd1,          32'hFFFF_FFFF,  32'd1,          1'b0);
        do_op("or_fill",      3'd2, 32'hF0F0_F0F0,  32'h0F0F_0F0F,  32'hFFFF_FFFF,  1'b0);
        do_op("and_clear",    3'd3, 32'hF0F0_F0F0,  32'h0F0F_0F0F,  32'd0,          1'b1);
        do_op("xor_mix",      3'd6, 32'hFF00_FF00,  32'h0FF0_0FF0,  32'hF0F0_F0F0,  1'b0);
        do_op("sll_4",        3'd7, 32'd4,          32'd1,          32'h0000_0010,  1'b0);
        do_op("sll_31",       3'd7, 32'd31,         32'd3,          32'h8000_0000,  1'b0);
        do_op("sll_0",        3'd7, 32'd0,          32'hDEAD_BEEF,  32'hDEAD_BEEF,  1'b0);
        do_op("sll_hi_ign",   3'd7, 32'hFFFF_FFE5,  32'd1,          32'h0000_0020,  1'b0);

        // Inputs changing between edges must not disturb the outputs.
        held = ALU_result;
        input_1 = 32'h0; input_2 = 32'h0; ALUop = 3'd3;
        #2;
        chk("hold_between_edges", ALU_result, held);

        // Back-to-back: a different op on every edge.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ALUop = ops[i]; input_1 = 32'd7 + 32'(i); input_2 = 32'h0000_0103 * 32'(i + 1);
        end

        // Pseudo-random mix, checked by the model.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ALUop = 3'($urandom_range(0, 7)); input_1 = $urandom; input_2 = $urandom;
        end

        // Reset asserted mid-stream drops the in-flight result at once.
        @(negedge clk);
        ALUop = 3'd0; input_1 = 32'd1; input_2 = 32'd2;
        @(posedge clk); #1;
        chk("pre_reset_result", ALU_result, 32'd3);
        #2; reset = 1; #1;
        chk("mid_reset_result", ALU_result, 32'd0);
        chk("mid_reset_zero", {31'd0, zero}, 32'd1);
        @(posedge clk); #1;
        chk("reset_held_result", ALU_result, 32'd0);
        @(negedge clk);
        reset = 0;
        do_op("post_reset_add", 3'd0, 32'd10, 32'd20, 32'd30, 1'b0);

        repeat (2) @(negedge clk);
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
